// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - pipeline, debug-port and data-memory signal bundle for the arbiter
interface data_mem_arbiter_if #(
  parameter int Bits = 64
);
  logic            cpu_mem_read;
  logic            cpu_mem_write;
  logic [Bits-1:0] cpu_addr;
  logic [Bits-1:0] cpu_wdata;
  logic [Bits-1:0] cpu_rdata;
  logic            cpu_stall;

  logic            dbg_req;
  logic            dbg_we;
  logic [Bits-1:0] dbg_addr;
  logic [Bits-1:0] dbg_wdata;
  logic            dbg_ack;
  logic [Bits-1:0] dbg_rdata;
  logic            dbg_err;

  logic [Bits-1:0] mem_access_addr;
  logic [Bits-1:0] mem_write_data;
  logic            mem_write_en;
  logic            mem_read;
  logic [Bits-1:0] mem_read_data;

  modport master (
    output cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata, dbg_err,
    input  mem_access_addr, mem_write_data, mem_write_en, mem_read,
    output mem_read_data
  );

  modport slave (
    input  cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata, dbg_err,
    output mem_access_addr, mem_write_data, mem_write_en, mem_read,
    input  mem_read_data
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares one data memory between the pipeline MEM stage and a debug/loader port
// The CPU has priority; the debug port wins when the CPU is idle or after STARVE_LIMIT lost cycles.
module data_mem_arbiter #(
  parameter int Bits         = 64,
  parameter int MemSize      = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_arbiter_if.slave   bus,
  output logic [15:0]         stall_count,
  output logic [15:0]         dbg_count
);
  localparam logic [0:0] ARB = 1'b0;
  localparam logic [0:0] ACK = 1'b1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [0:0]      state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            err_q, err_d;
  logic [Bits-1:0] rdata_q, rdata_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;
  logic [15:0]     dbg_cnt_q, dbg_cnt_d;

  logic cpu_access;
  logic dbg_win;
  logic in_range;

  assign cpu_access = bus.cpu_mem_read | bus.cpu_mem_write;
  assign in_range   = bus.dbg_addr < Bits'(MemSize);
  assign dbg_win    = (state_q == ARB) && bus.dbg_req &&
                      (!cpu_access || (starve_q == SW'(STARVE_LIMIT)));

  assign bus.cpu_stall = dbg_win & cpu_access;
  assign bus.cpu_rdata = bus.mem_read_data;
  assign bus.dbg_ack   = (state_q == ACK);
  assign bus.dbg_err   = err_q;
  assign bus.dbg_rdata = rdata_q;
  assign stall_count   = stall_cnt_q;
  assign dbg_count     = dbg_cnt_q;

  // An out-of-range debug win leaves the memory bus idle; a stalled CPU access is blocked.
  always_comb begin
    bus.mem_access_addr = '0;
    bus.mem_write_data  = '0;
    bus.mem_write_en    = 1'b0;
    bus.mem_read        = 1'b0;
    if (dbg_win) begin
      if (in_range) begin
        bus.mem_access_addr = bus.dbg_addr;
        bus.mem_write_data  = bus.dbg_wdata;
        bus.mem_write_en    = bus.dbg_we;
        bus.mem_read        = ~bus.dbg_we;
      end
    end else if (cpu_access) begin
      bus.mem_access_addr = bus.cpu_addr;
      bus.mem_write_data  = bus.cpu_wdata;
      bus.mem_write_en    = bus.cpu_mem_write;
      bus.mem_read        = bus.cpu_mem_read;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    stall_cnt_d = stall_cnt_q;
    dbg_cnt_d   = dbg_cnt_q;

    if (state_q == ARB) begin
      if (dbg_win) begin
        state_d  = ACK;
        starve_d = '0;
        err_d    = ~in_range;
        if (in_range && !bus.dbg_we) begin
          rdata_d = bus.mem_read_data;
        end
      end else if (!bus.dbg_req) begin
        starve_d = '0;
      end else if (starve_q != SW'(STARVE_LIMIT)) begin
        starve_d = starve_q + SW'(1);
      end
    end else begin
      state_d = ARB;
      err_d   = 1'b0;
      if (dbg_cnt_q != 16'hFFFF) begin
        dbg_cnt_d = dbg_cnt_q + 16'd1;
      end
    end

    if (bus.cpu_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB;
      starve_q    <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      stall_cnt_q <= '0;
      dbg_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      stall_cnt_q <= stall_cnt_d;
      dbg_cnt_q   <= dbg_cnt_d;
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter
module tb_data_mem_arbiter;
  localparam int Bits         = 64;
  localparam int MemSize      = 32;
  localparam int STARVE_LIMIT = 4;

  typedef struct {
    logic            err;
    logic [Bits-1:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] stall_count;
  logic [15:0] dbg_count;
  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb[$];

  data_mem_arbiter_if #(.Bits(Bits)) bus ();

  data_mem_arbiter #(
    .Bits(Bits), .MemSize(MemSize), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .stall_count(stall_count), .dbg_count(dbg_count)
  );

  always #5 clk = ~clk;

  logic [Bits-1:0] mem [0:MemSize-1];
  always @(posedge clk) begin
    if (bus.mem_write_en && (bus.mem_access_addr < MemSize))
      mem[bus.mem_access_addr[4:0]] <= bus.mem_write_data;
  end
  assign bus.mem_read_data = (bus.mem_read && (bus.mem_access_addr < MemSize)) ?
                             mem[bus.mem_access_addr[4:0]] : '0;

  task automatic check(input string name, input logic [Bits-1:0] act, input logic [Bits-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.dbg_ack === 1'b1) begin : mon
      exp_t e;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got dbg_ack=1 expected no pending request");
      end else begin
        e = sb.pop_front();
        check("ack_err", {63'd0, bus.dbg_err}, {63'd0, e.err});
        check("ack_rdata", bus.dbg_rdata, e.rdata);
      end
    end
  end

  // Called at posedge+1 in ARB; returns at posedge+1 in ARB after the ack cycle.
  task automatic dbg_access(input logic we, input logic [Bits-1:0] addr, input logic [Bits-1:0] wdata,
                            input logic exp_err, input logic [Bits-1:0] exp_rdata,
                            input int exp_lat, input logic [Bits-1:0] cpu_rd_exp, input string tag);
    exp_t e;
    int   k;
    e.err   = exp_err;
    e.rdata = exp_rdata;
    sb.push_back(e);
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = we;
    bus.dbg_addr  = addr;
    bus.dbg_wdata = wdata;
    k = 1;
    while (1) begin
      #2;
      check({tag, "_stall"}, {63'd0, bus.cpu_stall},
            {63'd0, (bus.cpu_mem_read | bus.cpu_mem_write) && (k == exp_lat)});
      if (bus.cpu_mem_read && k < exp_lat)
        check({tag, "_cpu_rdata"}, bus.cpu_rdata, cpu_rd_exp);
      if (exp_err && k == exp_lat)
        check({tag, "_no_mem_access"}, {62'd0, bus.mem_read, bus.mem_write_en}, 64'd0);
      @(posedge clk);
      #1;
      if (bus.dbg_ack) break;
      k++;
      if (k > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_timeout: got no dbg_ack expected ack within 50 cycles", tag);
        break;
      end
    end
    check({tag, "_latency"}, k, exp_lat);
    bus.dbg_req = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_ack_done"}, {62'd0, bus.dbg_ack, bus.dbg_err}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.cpu_mem_read = 0; bus.cpu_mem_write = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
    #12;
    check("rst_ack_err", {62'd0, bus.dbg_ack, bus.dbg_err}, 64'd0);
    check("rst_rdata", bus.dbg_rdata, 64'd0);
    check("rst_counts", {32'd0, stall_count, dbg_count}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    dbg_access(1'b1, 64'd3, 64'hAB, 1'b0, 64'd0, 1, 64'd0, "wr3");
    check("wr3_mem", mem[3], 64'hAB);
    check("wr3_dbg_count", {48'd0, dbg_count}, 64'd1);
    dbg_access(1'b1, 64'd7, 64'h55, 1'b0, 64'd0, 1, 64'd0, "wr7");
    dbg_access(1'b1, 64'd31, 64'h1F, 1'b0, 64'd0, 1, 64'd0, "wr31");
    check("wr31_mem", mem[31], 64'h1F);
    dbg_access(1'b0, 64'd3, 64'd0, 1'b0, 64'hAB, 1, 64'd0, "rd3");
    dbg_access(1'b0, 64'd31, 64'd0, 1'b0, 64'h1F, 1, 64'd0, "rd31");

    bus.cpu_mem_read = 1'b1;
    bus.cpu_addr     = 64'd7;
    dbg_access(1'b0, 64'd7, 64'd0, 1'b0, 64'h55, STARVE_LIMIT + 1, 64'h55, "starve");
    bus.cpu_mem_read = 1'b0;
    bus.cpu_addr     = 64'd0;
    check("starve_stall_count", {48'd0, stall_count}, 64'd1);
    check("starve_dbg_count", {48'd0, dbg_count}, 64'd6);

    dbg_access(1'b0, 64'd32, 64'd0, 1'b1, 64'h55, 1, 64'd0, "oob_rd");
    dbg_access(1'b1, 64'd40, 64'hEE, 1'b1, 64'h55, 1, 64'd0, "oob_wr");

    bus.cpu_mem_read = 1'b1; bus.cpu_mem_write = 1'b1;
    bus.cpu_addr = 64'd9; bus.cpu_wdata = 64'h99;
    #2;
    check("cpu_rw_ctrl", {61'd0, bus.mem_read, bus.mem_write_en, bus.cpu_stall}, 64'd6);
    check("cpu_rw_addr", bus.mem_access_addr, 64'd9);
    check("cpu_rw_wdata", bus.mem_write_data, 64'h99);
    @(posedge clk); #1;
    bus.cpu_mem_read = 1'b0; bus.cpu_mem_write = 1'b0;
    bus.cpu_addr = 64'd0; bus.cpu_wdata = 64'd0;
    #1;
    check("cpu_rw_mem", mem[9], 64'h99);
    check("idle_ctrl", {62'd0, bus.mem_read, bus.mem_write_en}, 64'd0);
    check("idle_addr_data", bus.mem_access_addr | bus.mem_write_data, 64'd0);

    @(posedge clk); #1;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 64'd4; bus.dbg_wdata = 64'h44;
    @(posedge clk); #1;
    check("rstack_ack_before", {63'd0, bus.dbg_ack}, 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rstack_ack_after", {63'd0, bus.dbg_ack}, 64'd0);
    check("rstack_counts", {32'd0, stall_count, dbg_count}, 64'd0);
    rst = 1'b0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = 64'd0; bus.dbg_wdata = 64'd0;
    @(posedge clk); #1;
    bus.cpu_mem_write = 1'b1; bus.cpu_addr = 64'd6; bus.cpu_wdata = 64'h66;
    #1;
    check("post_rst_store", {62'd0, bus.mem_write_en, bus.cpu_stall}, 64'd2);
    @(posedge clk); #1;
    bus.cpu_mem_write = 1'b0; bus.cpu_addr = 64'd0; bus.cpu_wdata = 64'd0;
    check("post_rst_mem6", mem[6], 64'h66);
    check("pre_rst_mem4", mem[4], 64'h44);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have these parameters: Bits, default 64, data/address width; MemSize, default 32, number of data-memory words; STARVE_LIMIT, default 4, maximum consecutive cycles the debug port may lose arbitration.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- cpu_mem_read  in  1  pipeline MEM-stage read request.
- cpu_mem_write  in  1  pipeline MEM-stage write request.
- cpu_addr  in  Bits  pipeline access address.
- cpu_wdata  in  Bits  pipeline write data.
- cpu_rdata  out  Bits  read data to pipeline.
- cpu_stall  out  1  pipeline must hold MEM stage this cycle.
- dbg_req  in  1  debug/loader request, held until dbg_ack.
- dbg_we  in  1  debug write (1) / read (0); stable while dbg_req.
- dbg_addr  in  Bits  debug address; stable while dbg_req.
- dbg_wdata  in  Bits  debug write data; stable while dbg_req.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  Bits  registered debug read data, valid with dbg_ack.
- dbg_err  out  1  with dbg_ack: address out of range, no access performed.
- mem_access_addr  out  Bits  to data memory.
- mem_write_data  out  Bits  to data memory.
- mem_write_en  out  1  to data memory.
- mem_read  out  1  to data memory.
- mem_read_data  in  Bits  from data memory, combinational, same-cycle valid.
- stall_count  out  16  saturating count of cpu_stall cycles.
- dbg_count  out  16  saturating count of completed debug accesses.

Function
REQ-003 The FSM SHALL have two states: ARB and ACK.
REQ-004 cpu_access SHALL be cpu_mem_read | cpu_mem_write; starve_cnt SHALL be a counter of width $clog2(STARVE_LIMIT+1).
REQ-005 In ARB, dbg_win SHALL be dbg_req & (~cpu_access | starve_cnt == STARVE_LIMIT); otherwise the CPU owns the memory.
REQ-006 When the CPU owns the memory, mem_* SHALL mirror the cpu_* inputs combinationally and cpu_rdata SHALL equal mem_read_data; read and write asserted together SHALL both pass through.
REQ-007 When dbg_win holds and dbg_addr < MemSize, the memory SHALL be driven from the dbg_* inputs, with mem_read = ~dbg_we and mem_write_en = dbg_we.
- On the edge, dbg_rdata SHALL capture mem_read_data for a read and hold its old value for a write.
- On the edge, the FSM SHALL go to ACK.
REQ-008 When dbg_win holds and dbg_addr >= MemSize, no memory access SHALL occur, dbg_err SHALL be set on the edge, and the FSM SHALL go to ACK.
REQ-009 cpu_stall SHALL equal dbg_win & cpu_access and is combinational; the stalled CPU access SHALL NOT reach the memory that cycle.
REQ-010 In ACK:
- dbg_ack SHALL be 1 for exactly this one cycle.
- The CPU SHALL own the memory unconditionally.
- dbg_req SHALL be ignored.
- The FSM SHALL return to ARB on the next edge, and dbg_err SHALL clear on that edge.
REQ-011 Debug access latency SHALL be one cycle from a winning request to dbg_ack; a debug request SHALL never be serviced twice, because of the ACK state.
REQ-012 starve_cnt SHALL follow these rules:
- Increments when dbg_req=1 in ARB and the CPU wins.
- Saturates at STARVE_LIMIT.
- Clears when dbg_win=1 or dbg_req=0.
- Holds in ACK.
REQ-013 When no requester is active, mem_write_en and mem_read SHALL be 0, mem_access_addr and mem_write_data SHALL be 0, and cpu_rdata SHALL be mem_read_data.
REQ-014 stall_count SHALL increment on each cycle with cpu_stall=1, and dbg_count on each dbg_ack cycle; both SHALL saturate at 16'hFFFF.
REQ-015 Deassertion of dbg_req before dbg_ack is a protocol violation; on such deassertion, an access already started SHALL complete.

Reset
REQ-016 While rst=1, independent of clk, the block SHALL hold:
- state = ARB, starve_cnt = 0.
- dbg_ack = 0, dbg_err = 0, dbg_rdata = 0.
- stall_count = 0, dbg_count = 0.
REQ-017 A reset asserted while in ACK SHALL abort the acknowledge, so no dbg_ack pulse appears; after reset the CPU SHALL have immediate access.

Verification
REQ-018 Idle CPU, debug write of 0xAB to address 3 -> next cycle dbg_ack=1, dbg_err=0, mem[3]=0xAB; dbg_count=1.
REQ-019 Debug read of address 3 with the CPU idle -> dbg_ack one cycle later with dbg_rdata=0xAB; cpu_stall remains 0 throughout.
REQ-020 Debug read while the CPU issues a load every cycle, STARVE_LIMIT=4 -> CPU served 4 cycles, 5th cycle cpu_stall=1 and debug served, dbg_ack on the 6th cycle; stall_count=1.
REQ-021 Debug read of address MemSize (32) -> dbg_ack=1 with dbg_err=1, no mem_read/mem_write_en asserted, dbg_rdata unchanged; dbg_err=0 on the following cycle.
REQ-022 rst pulsed mid-cycle while in ACK -> dbg_ack drops immediately, counters read 0, and the CPU store on the next cycle reaches the memory with cpu_stall=0.
